// File: rtl/rr_mux_4_if.sv
// Stream bundle around the 4-to-1 round-robin merge: four producer channels
// in, one registered consumer channel out, with the source tag alongside.
interface rr_mux_4_if #(
  parameter int DATA_WIDTH = 8
);

  // Producer side: one valid/ready pair per channel, data packed by channel.
  logic [3:0]              in_valid;
  logic [4*DATA_WIDTH-1:0] in_data;
  logic [3:0]              in_ready;

  // Consumer side: registered beat plus the index of the channel it came from.
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [1:0]              out_sel;
  logic                    out_ready;

  // The merge block itself.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel
  );

  // Whatever surrounds the merge: the producers and the consumer together.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel
  );

endinterface

// File: rtl/rr_mux_4.sv
// 4-to-1 stream multiplexer with round-robin arbitration.
// Four valid/ready producers are merged into one registered output beat. The
// beat carries a 2-bit tag naming its source channel, so a downstream 1-to-4
// demux can route it back. A rotating priority pointer starts the search at
// the channel after the last winner, which bounds every channel's wait to at
// most three other grants. in_ready is combinational but never depends on
// in_data.
module rr_mux_4 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_mux_4_if.slave    bus
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [1:0]            out_sel_q;
  logic [1:0]            ptr_q;       // channel searched first next time

  // ---------------------------------------------------------------------------
  // Arbitration signals
  // ---------------------------------------------------------------------------
  logic                  load;        // output register may take a new beat
  logic                  any_valid;   // at least one producer is offering
  logic [1:0]            winner;      // first valid channel from ptr_q upward
  logic                  accept;      // a handshake happens on this edge
  logic [DATA_WIDTH-1:0] winner_data;
  logic [3:0]            grant;

  // The register is free when it is empty, or when its beat leaves this cycle;
  // the latter is what gives back-to-back beats with no bubble.
  assign load = !out_valid_q || bus.out_ready;

  // Rotating search: try ptr, ptr+1, ptr+2, ptr+3 (mod 4), first valid wins.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // through the loop can leave it unassigned and infer a latch.
    any_valid = 1'b0;
    winner    = ptr_q;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] idx;
      idx = ptr_q + 2'(k);
      if (!any_valid && bus.in_valid[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
  end

  // Hold ready low during reset so no producer sees a handshake that the
  // reset branch of the register would then discard.
  assign accept = load && any_valid && !rst;

  // One-hot grant toward the winning producer, or nothing at all.
  always_comb begin
    grant = 4'b0000;
    if (accept) begin
      grant[winner] = 1'b1;
    end
  end

  // Data path mux; it feeds only the register, never the ready logic.
  always_comb begin
    winner_data = bus.in_data[DATA_WIDTH*int'(winner) +: DATA_WIDTH];
  end

  // Output register and priority pointer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, regardless of statement order.
    if (rst) begin
      // NOTE: the data and tag registers are reset too, not just the valid
      // flag, because their reset values are visible at the ports.
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'b00;
      ptr_q       <= 2'd0;
    end else if (load) begin
      if (any_valid) begin
        out_valid_q <= 1'b1;
        out_data_q  <= winner_data;
        out_sel_q   <= winner;
        ptr_q       <= winner + 2'd1;   // 3 wraps to 0
      end else begin
        // Drain with nothing behind it: go empty but keep the last payload.
        out_valid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Port drive
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = grant;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  // Never grant more than one producer in a cycle.
  a_grant_onehot0 : assert property (@(posedge clk) $onehot0(bus.in_ready));

  // A stalled beat stays put until the consumer takes it.
  a_hold_stable : assert property (
    @(posedge clk) disable iff (rst)
    (out_valid_q && !bus.out_ready) |=>
      (out_valid_q && $stable(out_data_q) && $stable(out_sel_q))
  );

  // No producer is offered ready while the register is stalled.
  a_no_grant_when_full : assert property (
    @(posedge clk) (!load) |-> (bus.in_ready == 4'b0000)
  );

endmodule

// File: tb/tb_rr_mux_4.sv
// Self-checking bench for rr_mux_4: directed vectors with literal expectations,
// plus a per-cycle comparison against a transaction-level model of the merge.
module tb_rr_mux_4;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rr_mux_4_if #(.DATA_WIDTH(DW)) bus ();

  rr_mux_4 #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: one held beat plus a "who is searched first" index.
  // ---------------------------------------------------------------------------
  bit         m_valid;
  logic [7:0] m_data;
  logic [1:0] m_sel;
  int         m_ptr;
  bit         cmp_en = 1'b0;

  // First valid channel scanning upward from p with wraparound, -1 if none.
  function automatic int pick(input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++) begin
      if (v[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int w;
    w = pick(bus.in_valid, m_ptr);
    if (rst || w < 0 || (m_valid && !bus.out_ready)) return 4'b0000;
    return 4'(1 << w);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_sel   <= 2'd0;
      m_ptr   <= 0;
    end else if (!m_valid || bus.out_ready) begin
      if (pick(bus.in_valid, m_ptr) >= 0) begin
        m_valid <= 1'b1;
        m_data  <= bus.in_data[pick(bus.in_valid, m_ptr)*DW +: DW];
        m_sel   <= 2'(pick(bus.in_valid, m_ptr));
        m_ptr   <= (pick(bus.in_valid, m_ptr) + 1) % 4;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  // Compare on the falling edge, away from register updates and input drive.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_in_ready", 32'(bus.in_ready), 32'(exp_ready()));
      check("cmp_out_valid", 32'(bus.out_valid), 32'(m_valid));
      if (m_valid) begin
        check("cmp_out_data", 32'(bus.out_data), 32'(m_data));
        check("cmp_out_sel", 32'(bus.out_sel), 32'(m_sel));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Advance one edge; return just after the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic r);
    bus.in_valid  = v;
    bus.out_ready = r;
    #1;
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    bus.in_data = {d3, d2, d1, d0};
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] d,
                            input logic [1:0] s);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, "_data"},  32'(bus.out_data),  32'(d));
    check({tag, "_sel"},   32'(bus.out_sel),   32'(s));
  endtask

  logic [7:0] fdat [4];
  logic [3:0] demux;
  logic [3:0] onehot_exp;

  initial begin
    fdat[0] = 8'h10; fdat[1] = 8'h21; fdat[2] = 8'h32; fdat[3] = 8'h43;
    bus.in_valid  = 4'b0000;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset for two cycles with every producer offering: nothing is granted.
    @(negedge clk); #1;
    set_data(8'h10, 8'h21, 8'h32, 8'h43);
    drive(4'b1111, 1'b1);
    cyc();
    cmp_en = 1'b1;
    cyc();
    expect_out("reset", 1'b0, 8'h00, 2'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'h0);

    // First beat after reset: channel 0, one cycle of latency.
    rst = 1'b0;
    set_data(8'hA0, 8'h00, 8'h00, 8'h00);
    drive(4'b0001, 1'b1);
    check("first_in_ready", 32'(bus.in_ready), 32'b0001);
    cyc();
    expect_out("first", 1'b1, 8'hA0, 2'd0);

    // Grant channel 3 alone so the pointer wraps back to 0.
    set_data(8'h10, 8'h21, 8'h32, 8'h43);
    drive(4'b1000, 1'b1);
    cyc();
    expect_out("wrap_to0", 1'b1, 8'h43, 2'd3);

    // Fairness: all four held valid, grants must rotate 0,1,2,3,0,1,2,3.
    drive(4'b1111, 1'b1);
    for (int i = 0; i < 8; i++) begin
      onehot_exp = 4'(1 << (i % 4));
      check("rr_in_ready", 32'(bus.in_ready), 32'(onehot_exp));
      cyc();
      expect_out("rr", 1'b1, fdat[i % 4], 2'(i % 4));
    end

    // Pointer skip: after a grant to ch2, 1001 picks ch3, then ch0.
    drive(4'b0100, 1'b1);
    cyc();
    expect_out("skip_ch2", 1'b1, 8'h32, 2'd2);
    drive(4'b1001, 1'b1);
    cyc();
    expect_out("skip_ch3", 1'b1, 8'h43, 2'd3);
    cyc();
    expect_out("skip_ch0", 1'b1, 8'h10, 2'd0);

    // Backpressure: 5C from ch1 must sit still while out_ready is low.
    set_data(8'h10, 8'h5C, 8'h32, 8'h43);
    drive(4'b0010, 1'b1);
    cyc();
    expect_out("bp_load", 1'b1, 8'h5C, 2'd1);
    drive(4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 32'(bus.in_ready), 32'h0);
      cyc();
      expect_out("bp_hold", 1'b1, 8'h5C, 2'd1);
    end
    drive(4'b1111, 1'b1);
    check("bp_release_ready", 32'(bus.in_ready), 32'b0100);
    cyc();
    expect_out("bp_next", 1'b1, 8'h32, 2'd2);

    // Bubble: nothing offered, output empties but keeps its payload.
    drive(4'b0000, 1'b1);
    cyc();
    expect_out("bubble", 1'b0, 8'h32, 2'd2);
    // Pointer still 3: with 1001 offered, ch3 must win over ch0.
    drive(4'b1001, 1'b1);
    cyc();
    expect_out("bubble_ptr", 1'b1, 8'h43, 2'd3);

    // Reset while a beat is stalled: it is dropped and ptr returns to 0.
    drive(4'b1111, 1'b0);
    rst = 1'b1;
    cyc();
    expect_out("midrst", 1'b0, 8'h00, 2'd0);
    rst = 1'b0;
    set_data(8'h10, 8'h21, 8'h32, 8'h43);
    drive(4'b1111, 1'b1);
    check("midrst_ptr0", 32'(bus.in_ready), 32'b0001);
    cyc();
    expect_out("midrst_next", 1'b1, 8'h10, 2'd0);
    drive(4'b0000, 1'b1);
    cyc();
    check("midrst_no_replay", 32'(bus.out_valid), 32'h0);

    // Round trip through a demux_4: data bit0 steered by out_sel.
    for (int i = 0; i < 4; i++) begin
      bus.in_data = '0;
      bus.in_data[i*DW +: DW] = 8'(8'h01 | (i << 4));
      drive(4'(1 << i), 1'b1);
      cyc();
      demux = 4'({3'b000, bus.out_data[0]} << bus.out_sel);
      onehot_exp = 4'(1 << i);
      check("demux_roundtrip", 32'(demux), 32'(onehot_exp));
    end

    // Mixed offers and stalls, checked only by the model.
    for (int c = 0; c < 40; c++) begin
      set_data(8'(c * 7), 8'(c * 7 + 1), 8'(c * 7 + 2), 8'(c * 7 + 3));
      drive(4'((c * 5 + 3) % 16), (c % 3) != 0);
      cyc();
    end

    drive(4'b0000, 1'b1);
    cyc();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Backstop so the run always ends even if the sequence above stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

endmodule
